// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALT control with jump, relative branch,
// and call/return through a small return-address stack with sticky error flag.
module pc_sequencer #(
    parameter int unsigned            ADDR_WIDTH  = 11,
    parameter int unsigned            STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0]  RESET_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  enable,
    input  logic                  halt_req,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    input  logic                  branch,
    input  logic [ADDR_WIDTH-1:0] branch_offset,
    input  logic                  call,
    input  logic                  ret,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  running,
    output logic                  halted,
    output logic                  stack_err
);

    localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned PtrW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [CntW-1:0]       sp_q, sp_d;
    logic                  err_q, err_d;
    logic                  running_q, halted_q;
    logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic                  push;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [PtrW-1:0]       wr_idx, rd_idx;

    assign addr_inc = address_q + ADDR_WIDTH'(1);
    assign wr_idx   = sp_q[PtrW-1:0];
    assign rd_idx   = PtrW'(sp_q - CntW'(1));

    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        sp_d      = sp_q;
        err_d     = err_q;
        push      = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                if (enable) begin
                    if (halt_req) begin
                        state_d = StHalt;
                    end else if (ret) begin
                        if (sp_q == '0) begin
                            err_d   = 1'b1;
                            state_d = StHalt;
                        end else begin
                            address_d = stack_q[rd_idx];
                            sp_d      = sp_q - CntW'(1);
                        end
                    end else if (call) begin
                        if (sp_q == CntW'(STACK_DEPTH)) begin
                            err_d   = 1'b1;
                            state_d = StHalt;
                        end else begin
                            push      = 1'b1;
                            sp_d      = sp_q + CntW'(1);
                            address_d = jump_addr;
                        end
                    end else if (jump) begin
                        address_d = jump_addr;
                    end else if (branch) begin
                        address_d = address_q + branch_offset;
                    end else begin
                        address_d = addr_inc;
                    end
                end
            end
            StHalt: begin
                // Restart clears the stack and the sticky error.
                if (start) begin
                    state_d   = StRun;
                    address_d = RESET_ADDR;
                    sp_d      = '0;
                    err_d     = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            address_q <= RESET_ADDR;
            sp_q      <= '0;
            err_q     <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            sp_q      <= sp_d;
            err_q     <= err_d;
            running_q <= (state_d == StRun);
            halted_q  <= (state_d == StHalt);
        end
    end

    // Entries above the pointer are don't-care, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) stack_q[wr_idx] <= addr_inc;
    end

    assign address   = address_q;
    assign running   = running_q;
    assign halted    = halted_q;
    assign stack_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized run
// compared against a queue-based behavioural model.
module tb_pc_sequencer;

    localparam int AW    = 11;
    localparam int DEPTH = 4;
    localparam int AMOD  = 2048;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0, enable = 1'b0, halt_req = 1'b0;
    logic          jump = 1'b0, branch = 1'b0, call = 1'b0, ret = 1'b0;
    logic [AW-1:0] jump_addr = '0, branch_offset = '0;
    logic [AW-1:0] address;
    logic          running, halted, stack_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 idle, 1 run, 2 halt.
    int m_addr, m_mode, m_err;
    int m_stack[$];

    always #5 clk = ~clk;

    pc_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(DEPTH), .RESET_ADDR('0)) dut (
        .clk(clk), .reset(reset), .start(start), .enable(enable), .halt_req(halt_req),
        .jump(jump), .jump_addr(jump_addr), .branch(branch), .branch_offset(branch_offset),
        .call(call), .ret(ret), .address(address), .running(running), .halted(halted),
        .stack_err(stack_err)
    );

    task automatic model_reset();
        m_addr = 0;
        m_mode = 0;
        m_err  = 0;
        m_stack.delete();
    endtask

    task automatic model_tick();
        if (m_mode == 0) begin
            if (start) m_mode = 1;
        end else if (m_mode == 1) begin
            if (enable) begin
                if (halt_req) m_mode = 2;
                else if (ret) begin
                    if (m_stack.size() == 0) begin m_err = 1; m_mode = 2; end
                    else m_addr = m_stack.pop_back();
                end else if (call) begin
                    if (m_stack.size() == DEPTH) begin m_err = 1; m_mode = 2; end
                    else begin
                        m_stack.push_back((m_addr + 1) % AMOD);
                        m_addr = int'(jump_addr);
                    end
                end else if (jump) m_addr = int'(jump_addr);
                else if (branch) m_addr = (m_addr + int'(branch_offset)) % AMOD;
                else m_addr = (m_addr + 1) % AMOD;
            end
        end else if (start) begin
            m_mode = 1;
            m_addr = 0;
            m_err  = 0;
            m_stack.delete();
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic clear_reqs();
        start = 0; halt_req = 0; jump = 0; branch = 0; call = 0; ret = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++;
        if (address !== 11'h000 || running !== 1'b0 || halted !== 1'b0 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state addr=%h run=%b halt=%b err=%b want 000/0/0/0",
                     address, running, halted, stack_err);
        end
        start = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (running !== 1'b0 || address !== 11'h000) begin
            errors++;
            $display("FAIL reset_hold run=%b addr=%h want 0/000", running, address);
        end
        clear_reqs();
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_count();
        start = 1;
        step();
        start = 0;
        checks++;
        if (running !== 1'b1 || address !== 11'h000) begin
            errors++;
            $display("FAIL start_run run=%b addr=%h want 1/000", running, address);
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (address !== AW'(i) || running !== 1'b1) begin
                errors++;
                $display("FAIL count addr=%h run=%b want %h/1", address, running, AW'(i));
            end
        end
    endtask

    task automatic test_wrap();
        jump = 1; jump_addr = 11'h7FF;
        step();
        jump = 0;
        checks++;
        if (address !== 11'h7FF) begin
            errors++;
            $display("FAIL jump_top addr=%h want 7ff", address);
        end
        step();
        checks++;
        if (address !== 11'h000 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL inc_wrap addr=%h err=%b want 000/0", address, stack_err);
        end
    endtask

    task automatic test_call_ret();
        jump = 1; jump_addr = 11'h010;
        step();
        jump = 0;
        call = 1; jump_addr = 11'h100;
        step();
        call = 0;
        checks++;
        if (address !== 11'h100) begin
            errors++;
            $display("FAIL call_target addr=%h want 100", address);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (address !== AW'(11'h100 + i)) begin
                errors++;
                $display("FAIL call_inc addr=%h want %h", address, AW'(11'h100 + i));
            end
        end
        ret = 1;
        step();
        ret = 0;
        checks++;
        if (address !== 11'h011) begin
            errors++;
            $display("FAIL ret_addr addr=%h want 011", address);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            call = 1; jump_addr = AW'(11'h200 + 16 * i);
            step();
            call = 0;
            if (i < 4) begin
                checks++;
                if (address !== AW'(11'h200 + 16 * i) || stack_err !== 1'b0) begin
                    errors++;
                    $display("FAIL call_n addr=%h err=%b want %h/0", address, stack_err,
                             AW'(11'h200 + 16 * i));
                end
            end
        end
        checks++;
        if (stack_err !== 1'b1 || halted !== 1'b1 || running !== 1'b0 || address !== 11'h230) begin
            errors++;
            $display("FAIL overflow err=%b halt=%b run=%b addr=%h want 1/1/0/230",
                     stack_err, halted, running, address);
        end
        jump = 1; jump_addr = 11'h055;
        step();
        jump = 0;
        checks++;
        if (address !== 11'h230 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_ignore addr=%h halt=%b want 230/1", address, halted);
        end
        start = 1;
        step();
        start = 0;
        checks++;
        if (running !== 1'b1 || address !== 11'h000 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL restart run=%b addr=%h err=%b want 1/000/0", running, address, stack_err);
        end
        ret = 1;
        step();
        ret = 0;
        checks++;
        if (stack_err !== 1'b1 || halted !== 1'b1 || address !== 11'h000) begin
            errors++;
            $display("FAIL underflow err=%b halt=%b addr=%h want 1/1/000", stack_err, halted, address);
        end
    endtask

    task automatic test_priority();
        start = 1;
        step();
        start = 0;
        jump = 1; jump_addr = 11'h005;
        step();
        branch = 1; branch_offset = 11'h7FE; call = 1; jump_addr = 11'h050;
        step();
        clear_reqs();
        ret = 1;
        step();
        ret = 0;
        checks++;
        if (address !== 11'h006 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL call_wins addr=%h err=%b want 006/0", address, stack_err);
        end
        jump = 1; jump_addr = 11'h005;
        step();
        jump = 0;
        branch = 1; branch_offset = 11'h7FE;
        step();
        checks++;
        if (address !== 11'h003) begin
            errors++;
            $display("FAIL branch_back addr=%h want 003", address);
        end
        enable = 0;
        call = 1; halt_req = 1;
        step();
        enable = 1;
        clear_reqs();
        checks++;
        if (address !== 11'h003 || running !== 1'b1) begin
            errors++;
            $display("FAIL stall addr=%h run=%b want 003/1", address, running);
        end
        branch = 1; branch_offset = 11'h7FE;
        step();
        step();
        step();
        branch = 0;
        checks++;
        if (address !== 11'h7FD) begin
            errors++;
            $display("FAIL branch_wrap addr=%h want 7fd", address);
        end
    endtask

    task automatic test_async_reset();
        jump = 1; jump_addr = 11'h100;
        step();
        jump = 0;
        call = 1; jump_addr = 11'h123;
        step();
        call = 0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (address !== 11'h000 || running !== 1'b0 || halted !== 1'b0 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset addr=%h run=%b halt=%b err=%b want 000/0/0/0",
                     address, running, halted, stack_err);
        end
        reset = 1'b1;
        jump = 1; jump_addr = 11'h077;
        step();
        step();
        jump = 0;
        checks++;
        if (address !== 11'h000 || running !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset addr=%h run=%b want 000/0", address, running);
        end
        start = 1;
        step();
        start = 0;
        ret = 1;
        step();
        ret = 0;
        checks++;
        if (stack_err !== 1'b1 || halted !== 1'b1) begin
            errors++;
            $display("FAIL stack_cleared err=%b halt=%b want 1/1", stack_err, halted);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            start         = ($urandom % 12) == 0;
            enable        = ($urandom % 4) != 0;
            halt_req      = ($urandom % 40) == 0;
            ret           = ($urandom % 6) == 0;
            call          = ($urandom % 6) == 0;
            jump          = ($urandom % 5) == 0;
            branch        = ($urandom % 3) == 0;
            jump_addr     = AW'($urandom);
            branch_offset = AW'($urandom);
            step();
            if (($urandom % 97) == 0) begin
                #2 reset = 1'b0;
                #1 model_reset();
                reset = 1'b1;
            end
            checks++;
            if (address !== AW'(m_addr) || running !== (m_mode == 1) ||
                halted !== (m_mode == 2) || stack_err !== m_err[0]) begin
                errors++;
                $display("FAIL random n=%0d addr=%h run=%b halt=%b err=%b want %h/%0b/%0b/%0b",
                         n, address, running, halted, stack_err, AW'(m_addr),
                         m_mode == 1, m_mode == 2, m_err[0]);
            end
        end
        clear_reqs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count();
        test_wrap();
        test_call_ret();
        test_overflow();
        test_priority();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 11, meaning address/program-count width in bits.
REQ-002 The block SHALL have parameter STACK_DEPTH, default 4, meaning return-address stack entries (>=1).
REQ-003 The block SHALL have parameter RESET_ADDR, default 0, meaning start address loaded on reset and restart.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port start, input, 1: begin/restart execution.
REQ-007 Port enable, input, 1: advance permission; 0 = stall.
REQ-008 Port halt_req, input, 1: stop execution.
REQ-009 Port jump, input, 1: absolute jump request.
REQ-010 Port jump_addr, input, ADDR_WIDTH: absolute target.
REQ-011 Port branch, input, 1: relative branch request.
REQ-012 Port branch_offset, input, ADDR_WIDTH: two's-complement signed offset.
REQ-013 Port call, input, 1: jump to jump_addr and push return address.
REQ-014 Port ret, input, 1: pop return address.
REQ-015 Port address, output, ADDR_WIDTH: current program count (registered).
REQ-016 Port running, output, 1: high in RUN state.
REQ-017 Port halted, output, 1: high in HALT state.
REQ-018 Port stack_err, output, 1: sticky overflow/underflow flag.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, HALT; all outputs registered.
REQ-020 IDLE: address holds RESET_ADDR; start=1 -> RUN next cycle, address unchanged.
REQ-021 RUN with enable=0 SHALL hold address, stack and state; all requests ignored.
REQ-022 RUN with enable=1 SHALL apply exactly one action per cycle, priority halt_req > ret > call > jump > branch > increment.
REQ-023 halt_req: state -> HALT, address unchanged.
REQ-024 ret: address <= top of stack, stack pointer decrements.
REQ-025 call: push address+1 (mod 2^ADDR_WIDTH), address <= jump_addr.
REQ-026 jump: address <= jump_addr.
REQ-027 branch: address <= address + branch_offset, truncated to ADDR_WIDTH (wraps both directions).
REQ-028 No request: address <= address + 1 mod 2^ADDR_WIDTH; all-ones wraps to 0 without error.
REQ-029 call with stack full (STACK_DEPTH entries) SHALL not push, set stack_err, go to HALT, hold address.
REQ-030 ret with stack empty SHALL set stack_err, go to HALT, hold address.
REQ-031 Stack occupancy SHALL be tracked with a counter of width clog2(STACK_DEPTH+1); one push or pop per cycle max.
REQ-032 HALT: address held; start=1 -> RUN with address <= RESET_ADDR, stack emptied, stack_err cleared.
REQ-033 start in RUN SHALL be ignored.
REQ-034 Requests in IDLE or HALT SHALL be ignored (except start).

Reset
REQ-035 reset=0 SHALL immediately force state IDLE, address=RESET_ADDR, stack empty, running=0, halted=0, stack_err=0, regardless of clk.
REQ-036 Deassertion of reset mid-operation SHALL resume from IDLE only; no prior state retained.

Verification
REQ-037 reset low, start pulse, enable=1 for 5 cycles -> address 0,1,2,3,4,5; running=1.
REQ-038 ADDR_WIDTH=11, jump to 0x7FF then increment -> address 0x7FF then 0x000, stack_err=0.
REQ-039 address 0x010, call jump_addr=0x100, then 3 increments, then ret -> 0x100,0x101,0x102,0x103,0x011.
REQ-040 STACK_DEPTH=4, five consecutive calls -> fifth sets stack_err=1, halted=1, address = fourth target; ret on empty after restart -> stack_err=1, HALT.
REQ-041 address 0x005, branch offset 0x7FE (-2), with jump and call also asserted -> call wins; repeat with only branch -> 0x003; enable=0 during request -> address held.
REQ-042 reset asserted asynchronously between clock edges while RUN at 0x123 with stack non-empty -> address=RESET_ADDR immediately, all flags 0, IDLE until start.
